// File: rtl/morse_pkg.sv
// Shared symbol codes, FSM state type and per-symbol unit counts for the Morse transmitter.
package morse_pkg;

  localparam logic [1:0] SYM_DOT  = 2'b00;
  localparam logic [1:0] SYM_DASH = 2'b01;
  localparam logic [1:0] SYM_LGAP = 2'b10;
  localparam logic [1:0] SYM_WGAP = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2
  } morse_tx_state_t;

  localparam logic [2:0] DOT_MARK   = 3'd1;
  localparam logic [2:0] DOT_SPACE  = 3'd1;
  localparam logic [2:0] DASH_MARK  = 3'd3;
  localparam logic [2:0] DASH_SPACE = 3'd1;
  localparam logic [2:0] LGAP_MARK  = 3'd0;
  localparam logic [2:0] LGAP_SPACE = 3'd2;
  localparam logic [2:0] WGAP_MARK  = 3'd0;
  localparam logic [2:0] WGAP_SPACE = 3'd6;

  function automatic logic [2:0] mark_units(input logic [1:0] s);
    case (s)
      SYM_DOT:  mark_units = DOT_MARK;
      SYM_DASH: mark_units = DASH_MARK;
      SYM_LGAP: mark_units = LGAP_MARK;
      default:  mark_units = WGAP_MARK;
    endcase
  endfunction

  function automatic logic [2:0] space_units(input logic [1:0] s);
    case (s)
      SYM_DOT:  space_units = DOT_SPACE;
      SYM_DASH: space_units = DASH_SPACE;
      SYM_LGAP: space_units = LGAP_SPACE;
      default:  space_units = WGAP_SPACE;
    endcase
  endfunction

endpackage

// File: rtl/sos_beacon_seq.sv
// SOS beacon sequencer: walks a 12-symbol ROM and offers each symbol to the transmitter core.
module sos_beacon_seq
  import morse_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       beacon_en,
  input  logic       core_ready,
  output logic       bcn_valid,
  output logic [1:0] bcn_sym
);

  logic [3:0] idx;

  always_comb begin
    bcn_sym = SYM_DOT;
    case (idx)
      4'd3, 4'd7:        bcn_sym = SYM_LGAP;
      4'd4, 4'd5, 4'd6:  bcn_sym = SYM_DASH;
      4'd11:             bcn_sym = SYM_WGAP;
      default:           bcn_sym = SYM_DOT;
    endcase
  end

  assign bcn_valid = beacon_en;

  // The core keeps running whatever it already captured, so clearing here
  // on deassert still lets the in-flight symbol finish.
  always_ff @(posedge clk) begin
    if (rst || !beacon_en) idx <= '0;
    else if (core_ready)   idx <= (idx == 4'd11) ? 4'd0 : idx + 4'd1;
  end

endmodule

// File: rtl/morse_sym_tx.sv
// On/off keyed Morse symbol transmitter with valid/ready symbol input.
// Optional SOS beacon sequencer enabled by defining MORSE_SOS_BEACON_EN.
module morse_sym_tx
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sym_valid,
  input  logic [1:0] sym,
  output logic       sym_ready,
  output logic       out,
  output logic       busy
`ifdef MORSE_SOS_BEACON_EN
  ,
  input  logic       beacon_en
`endif
);

  localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

  morse_tx_state_t state;
  logic [CW-1:0]   cyc;
  logic [2:0]      units;
  logic [2:0]      space_q;
  logic            core_valid;
  logic [1:0]      core_sym;
  logic            core_ready;
  logic            unit_end;
  logic            last_unit;
  logic            accept;

`ifdef MORSE_SOS_BEACON_EN
  logic       bcn_valid;
  logic [1:0] bcn_sym;

  sos_beacon_seq u_seq (
    .clk        (clk),
    .rst        (rst),
    .beacon_en  (beacon_en),
    .core_ready (core_ready),
    .bcn_valid  (bcn_valid),
    .bcn_sym    (bcn_sym)
  );

  assign core_valid = beacon_en ? bcn_valid : sym_valid;
  assign core_sym   = beacon_en ? bcn_sym   : sym;
  assign sym_ready  = core_ready && !beacon_en;
`else
  assign core_valid = sym_valid;
  assign core_sym   = sym;
  assign sym_ready  = core_ready;
`endif

  assign unit_end   = (cyc == CW'(UNIT_CYCLES - 1));
  assign last_unit  = unit_end && (units == 3'd1);
  assign core_ready = (state == ST_IDLE) || ((state == ST_SPACE) && last_unit);
  assign accept     = core_valid && core_ready;
  assign busy       = (state != ST_IDLE);

  // Accept is only possible in IDLE or the last SPACE cycle, so it takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      out     <= 1'b0;
      cyc     <= '0;
      units   <= '0;
      space_q <= '0;
    end else if (accept) begin
      cyc     <= '0;
      space_q <= space_units(core_sym);
      if (mark_units(core_sym) != 3'd0) begin
        state <= ST_MARK;
        units <= mark_units(core_sym);
        out   <= 1'b1;
      end else begin
        state <= ST_SPACE;
        units <= space_units(core_sym);
        out   <= 1'b0;
      end
    end else begin
      case (state)
        ST_MARK: begin
          if (!unit_end) cyc <= cyc + 1'b1;
          else begin
            cyc <= '0;
            if (units == 3'd1) begin
              state <= ST_SPACE;
              units <= space_q;
              out   <= 1'b0;
            end else begin
              units <= units - 3'd1;
            end
          end
        end
        ST_SPACE: begin
          if (!unit_end) cyc <= cyc + 1'b1;
          else begin
            cyc <= '0;
            if (units == 3'd1) begin
              state <= ST_IDLE;
              units <= '0;
            end else begin
              units <= units - 3'd1;
            end
          end
        end
        default: begin
          out   <= 1'b0;
          cyc   <= '0;
          units <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/morse_sym_tx.md
# morse_sym_tx

Serial Morse symbol transmitter for the SOS detector datapath. It accepts Morse symbols (dot, dash, letter gap, word gap) over a valid/ready handshake and drives them as an on/off keyed bit stream. The stream's bit format is the one the dot and dash detectors consume: a dot is one unit high then one unit low, and a dash is three units high then one unit low. The block sources stimulus and loopback traffic for the detector chain.

## Interface
- `UNIT_CYCLES`, default 1: clock cycles per Morse unit; legal range ≥1.
- `clk`  in  1: clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `sym_valid`  in  1: `sym` holds a symbol to send.
- `sym`  in  2: symbol code; see Operation.
- `sym_ready`  out  1: block will accept `sym` at this edge.
- `out`  out  1: keyed serial output, registered.
- `busy`  out  1: a symbol is in progress (state ≠ IDLE).
- `beacon_en`  in  1: present only with `MORSE_SOS_BEACON_EN`; see Configuration.

## Operation
- Symbol codes (mark units high, then space units low):
  - `SYM_DOT` = 2'b00: 1 high, 1 low.
  - `SYM_DASH` = 2'b01: 3 high, 1 low.
  - `SYM_LGAP` = 2'b10: 0 high, 2 low. Adds to the trailing low unit of the previous symbol to give 3.
  - `SYM_WGAP` = 2'b11: 0 high, 6 low. Adds to the trailing low unit to give 7.
- FSM states: IDLE, MARK, SPACE.
  - IDLE → MARK on accept of DOT or DASH.
  - IDLE → SPACE on accept of LGAP or WGAP.
  - MARK → SPACE when the mark unit count is exhausted.
  - SPACE → IDLE when the space count is exhausted and there is no accept in that cycle.
  - SPACE → MARK or SPACE (new symbol) when an accept occurs in the last SPACE cycle.
- Handshake: accept = `sym_valid && sym_ready` at a rising edge.
  - `sym_ready` = 1 in IDLE, and in the final cycle of SPACE.
  - `sym_ready` = 0 otherwise.
  - `sym` is captured at accept. Later changes to `sym` have no effect on the symbol in progress.
- Counters:
  - Cycle-in-unit counter: width max(1, $clog2(UNIT_CYCLES)), wraps at UNIT_CYCLES−1.
  - Units-remaining counter: 3 bits (max 6).
  - Both counters reload on every state entry.
- `out` = 1 exactly during MARK cycles, 0 otherwise.
- `sym_valid` low while in IDLE: the block stays in IDLE with `out`=0.

## Timing
- Reset values: `out`=0, `busy`=0, `sym_ready`=1, state IDLE, all counters 0.
- Latency: accept at edge E → `out` reflects the symbol's first unit in the cycle after E. Zero idle cycles between accepted symbols.
- Symbol duration in cycles = UNIT_CYCLES × total units:
  - DOT: 2 units.
  - DASH: 4 units.
  - LGAP: 2 units.
  - WGAP: 6 units.
- `busy` is high for the full symbol duration. It falls in the cycle after the last SPACE cycle if there is no new accept.
- Reset mid-symbol: at the reset edge, state → IDLE, `out`=0, `busy`=0. The symbol in progress is dropped. Reset wins over a simultaneous accept.

## Configuration
- `MORSE_SOS_BEACON_EN` defined:
  - Adds the `beacon_en` port and an internal SOS sequencer.
  - While `beacon_en`=1, `sym_ready`=0 to the external interface and external `sym` is ignored.
  - The sequencer feeds a repeating 12-symbol loop: DOT DOT DOT LGAP DASH DASH DASH LGAP DOT DOT DOT WGAP, using the same accept timing.
  - On `beacon_en` deassert, the current symbol completes, then the sequence index returns to 0.
  - Reset clears the index.
- `MORSE_SOS_BEACON_EN` undefined: no port, no sequencer, and behaviour is exactly as above.

## Structure
- Shared package `morse_pkg` holds:
  - Symbol codes `SYM_DOT`, `SYM_DASH`, `SYM_LGAP`, `SYM_WGAP`.
  - FSM state enum `morse_tx_state_t`.
  - Mark and space unit-count constants per symbol.
- Sub-module `sos_beacon_seq`: 4-bit index, symbol ROM, and handshake master. It is instantiated only under the macro.

## Test plan
- Reset, UNIT_CYCLES=1 → `out`=0, `busy`=0, `sym_ready`=1; these values hold with `sym_valid`=0 for 10 cycles.
- Accept DOT, UNIT_CYCLES=1 → `out`=1,0 over two cycles. `sym_ready`=1 in the 0 cycle, then IDLE.
- Back-to-back DOT, DASH, DOT with `sym_valid` held high → `out`=1,0,1,1,1,0,1,0 with no gaps. `sym_ready` pulses only in the final cycle of each SPACE.
- UNIT_CYCLES=4, DASH then WGAP → 12 cycles high, then 4+24 cycles low. `busy` is high for 40 cycles.
- Reset asserted in the 2nd high cycle of a DASH → next cycle `out`=0, `busy`=0, `sym_ready`=1. A following DOT transmits normally.
- With macro, UNIT_CYCLES=1, `beacon_en`=1 → 34-cycle period: 101010 00 111011101110 00 101010 000000. External `sym_valid` is ignored throughout.
